// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with a two-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_STALL_CNT_EN to build the saturating stall counter behind stall_cnt.
module pipe_stage_reg #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   output logic [CNT_W-1:0] stall_cnt
);
   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic             acc;
   logic             drain;
   assign in_ready = !skid_valid;
   assign acc      = in_valid & in_ready;
   assign drain    = out_valid & out_ready;
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
         out_data   <= RESET_VAL;
         skid_data  <= RESET_VAL;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (skid_valid) begin
         if (drain) begin
            out_data   <= skid_data;
            skid_valid <= 1'b0;
         end
      end else if (acc && (!out_valid || out_ready)) begin
         out_data  <= in_data;
         out_valid <= 1'b1;
      end else if (acc) begin
         skid_data  <= in_data;
         skid_valid <= 1'b1;
      end else if (drain) begin
         out_valid <= 1'b0;
      end
   end
`ifdef PIPE_STAGE_STALL_CNT_EN
   // saturates rather than wraps so long stalls stay visible
   always_ff @(posedge clk) begin
      if (!rst)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
         stall_cnt <= stall_cnt + 1'b1;
   end
`else
   assign stall_cnt = '0;
`endif
endmodule
